// File: rtl/instruction_fetch_buffer.sv
// Fetch stage for the single-cycle datapath: owns the fetch PC, issues word reads
// to a variable-latency instruction memory (req/gnt + in-order rvalid) and buffers
// the returned words in a DEPTH-entry prefetch FIFO presented to decode as
// {pc, instruction} over valid/ready. Supports redirect (flush + discard of
// in-flight responses) and halt.
// Optional feature: define IFETCH_MISALIGN_TRAP_EN to add o_misalign, which traps
// a redirect to a non-word-aligned address by entering HALT until an aligned redirect.
module instruction_fetch_buffer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 4
) (
   input  logic        i_clk,
   input  logic        i_arstn,
   output logic        o_memReq,
   output logic [31:0] o_memAddr,
   input  logic        i_memGnt,
   input  logic        i_memRvalid,
   input  logic [31:0] i_memRdata,
   output logic        o_valid,
   output logic [31:0] o_instruction,
   output logic [31:0] o_pc,
   input  logic        i_ready,
   input  logic        i_redirect,
   input  logic [31:0] i_redirectPc,
`ifdef IFETCH_MISALIGN_TRAP_EN
   output logic        o_misalign,
`endif
   input  logic        i_halt
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned SW = CW + 2;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      HALT  = 2'd2
   } fetchState_e;

   fetchState_e   state_q, state_d;
   logic [31:0]   fetchPc_q, fetchPc_d;
   logic [31:0]   tailPc_q, tailPc_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] outstanding_q, outstanding_d;
   logic [CW-1:0] discard_q, discard_d;
   logic [PW-1:0] rdPtr_q, rdPtr_d;
   logic [PW-1:0] wrPtr_q, wrPtr_d;
   logic [31:0]   memPc_q    [DEPTH];
   logic [31:0]   memInstr_q [DEPTH];

   logic          redirectEff;
   logic          memReq;
   logic          grant;
   logic          rspAccepted;
   logic          push;
   logic          pop;
   logic          headValid;
   logic [SW-1:0] creditSum;
   logic [SW-1:0] inFlight;
   logic [31:0]   redirectPcAligned;

`ifdef IFETCH_MISALIGN_TRAP_EN
   logic          misalign_q, misalign_d;
   logic          redirectMisaligned;

   assign redirectMisaligned = |i_redirectPc[1:0];
   assign o_misalign         = misalign_q;
`endif

   // A redirect arriving while still in BOOT is ignored entirely.
   assign redirectEff       = i_redirect && (state_q != BOOT);
   assign redirectPcAligned = i_redirectPc & 32'hFFFF_FFFC;

   // Every request must have a guaranteed FIFO slot: entries already buffered,
   // responses still owed to the FIFO and stale responses still to be dropped
   // all consume credit.
   assign creditSum   = SW'(count_q) + SW'(outstanding_q) + SW'(discard_q);
   assign inFlight    = SW'(outstanding_q) + SW'(discard_q);
   assign memReq      = (state_q == FETCH) && !i_redirect && (creditSum < SW'(DEPTH));
   assign grant       = memReq && i_memGnt;
   assign rspAccepted = i_memRvalid && (inFlight != '0);
   assign push        = rspAccepted && !redirectEff && (discard_q == '0);
   assign headValid   = (count_q != '0);
   assign pop         = headValid && i_ready;

   assign o_memReq      = memReq;
   assign o_memAddr     = fetchPc_q;
   assign o_valid       = headValid;
   assign o_pc          = headValid ? memPc_q[rdPtr_q]    : 32'h0;
   assign o_instruction = headValid ? memInstr_q[rdPtr_q] : 32'h0;

   // Next-state logic for the BOOT/FETCH/HALT controller (and misalign trap).
   always_comb begin
      state_d = state_q;
`ifdef IFETCH_MISALIGN_TRAP_EN
      misalign_d = misalign_q;
`endif
      case (state_q)
         BOOT:    state_d = FETCH;
         FETCH:   if (i_halt) state_d = HALT;
`ifdef IFETCH_MISALIGN_TRAP_EN
         HALT:    if (!i_halt && !misalign_q) state_d = FETCH;
`else
         HALT:    if (!i_halt) state_d = FETCH;
`endif
         default: state_d = BOOT;
      endcase
`ifdef IFETCH_MISALIGN_TRAP_EN
      if (redirectEff) begin
         if (redirectMisaligned) begin
            misalign_d = 1'b1;
            state_d    = HALT;
         end else begin
            misalign_d = 1'b0;
            state_d    = i_halt ? HALT : FETCH;
         end
      end
`endif
   end

   // Fetch PC, FIFO pointers and the three credit counters. A redirect flushes
   // the FIFO and turns everything still in flight into stale responses; an
   // rvalid landing on the redirect cycle retires one of those immediately.
   always_comb begin
      fetchPc_d     = fetchPc_q;
      tailPc_d      = tailPc_q;
      count_d       = count_q;
      outstanding_d = outstanding_q;
      discard_d     = discard_q;
      rdPtr_d       = rdPtr_q;
      wrPtr_d       = wrPtr_q;
      if (redirectEff) begin
         fetchPc_d     = redirectPcAligned;
         tailPc_d      = redirectPcAligned;
         count_d       = '0;
         outstanding_d = '0;
         rdPtr_d       = '0;
         wrPtr_d       = '0;
         discard_d     = rspAccepted ? CW'(inFlight - SW'(1)) : CW'(inFlight);
      end else begin
         if (grant) begin
            fetchPc_d = fetchPc_q + 32'd4;
         end
         outstanding_d = outstanding_q + CW'(grant) - CW'(push);
         if (rspAccepted && (discard_q != '0)) begin
            discard_d = discard_q - CW'(1);
         end
         if (push) begin
            wrPtr_d  = wrPtr_q + PW'(1);
            tailPc_d = tailPc_q + 32'd4;
         end
         if (pop) begin
            rdPtr_d = rdPtr_q + PW'(1);
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   // Control state register with asynchronous reset back to BOOT at RESET_PC.
   always_ff @(posedge i_clk or negedge i_arstn) begin
      if (!i_arstn) begin
         state_q       <= BOOT;
         fetchPc_q     <= RESET_PC;
         tailPc_q      <= RESET_PC;
         count_q       <= '0;
         outstanding_q <= '0;
         discard_q     <= '0;
         rdPtr_q       <= '0;
         wrPtr_q       <= '0;
`ifdef IFETCH_MISALIGN_TRAP_EN
         misalign_q    <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         fetchPc_q     <= fetchPc_d;
         tailPc_q      <= tailPc_d;
         count_q       <= count_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
         rdPtr_q       <= rdPtr_d;
         wrPtr_q       <= wrPtr_d;
`ifdef IFETCH_MISALIGN_TRAP_EN
         misalign_q    <= misalign_d;
`endif
      end
   end

   // FIFO storage; contents need no reset because the head is masked while empty.
   always_ff @(posedge i_clk) begin
      if (push) begin
         memPc_q[wrPtr_q]    <= tailPc_q;
         memInstr_q[wrPtr_q] <= i_memRdata;
      end
   end

endmodule

// File: tb/tb_instruction_fetch_buffer.sv
// Directed self-checking bench for instruction_fetch_buffer (DEPTH=4, RESET_PC=0).
// A small memory model answers every grant in order with a word derived from its
// address; every instruction popped by decode is compared against the PC sequence
// the bench expects.
module tb_instruction_fetch_buffer;

   logic        i_clk;
   logic        i_arstn;
   logic        o_memReq;
   logic [31:0] o_memAddr;
   logic        i_memGnt;
   logic        i_memRvalid;
   logic [31:0] i_memRdata;
   logic        o_valid;
   logic [31:0] o_instruction;
   logic [31:0] o_pc;
   logic        i_ready;
   logic        i_redirect;
   logic [31:0] i_redirectPc;
   logic        i_halt;
`ifdef IFETCH_MISALIGN_TRAP_EN
   logic        o_misalign;
`endif

   int          compareCount;
   int          failCount;
   int          popCount;
   int          grantCount;
   int          popBefore;
   logic [31:0] expPc;
   logic        respEn;
   logic        injectOne;
   logic [31:0] pendingQ [$];

   instruction_fetch_buffer dut (
      .i_clk         (i_clk),
      .i_arstn       (i_arstn),
      .o_memReq      (o_memReq),
      .o_memAddr     (o_memAddr),
      .i_memGnt      (i_memGnt),
      .i_memRvalid   (i_memRvalid),
      .i_memRdata    (i_memRdata),
      .o_valid       (o_valid),
      .o_instruction (o_instruction),
      .o_pc          (o_pc),
      .i_ready       (i_ready),
      .i_redirect    (i_redirect),
      .i_redirectPc  (i_redirectPc),
`ifdef IFETCH_MISALIGN_TRAP_EN
      .o_misalign    (o_misalign),
`endif
      .i_halt        (i_halt)
   );

   // Free-running 10 ns clock.
   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   // Hard stop in case something stalls the main sequence.
   initial begin
      #100000;
      $display("[TB] FAIL timeout: bench did not finish within time limit");
      $fatal(1, "[TB] timeout");
   end

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compareCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // One clock cycle: check any pop decode performs, clock the DUT, then let the
   // memory model record the grant and drive the next in-order response.
   task automatic applyStimulus();
      logic        grantNow;
      logic [31:0] addrNow;
      #1;
      grantNow = o_memReq && i_memGnt;
      addrNow  = o_memAddr;
      if (o_valid && i_ready) begin
         checkOutput("popPc", o_pc, expPc);
         checkOutput("popInstr", o_instruction, memWord(expPc));
         expPc = expPc + 32'd4;
         popCount++;
      end
      @(posedge i_clk);
      #1;
      if (grantNow) begin
         pendingQ.push_back(addrNow);
         grantCount++;
      end
      if (injectOne) begin
         i_memRvalid = 1'b1;
         i_memRdata  = 32'h0BAD_0BAD;
         injectOne   = 1'b0;
      end else if (respEn && (pendingQ.size() > 0)) begin
         i_memRvalid = 1'b1;
         i_memRdata  = memWord(pendingQ.pop_front());
      end else begin
         i_memRvalid = 1'b0;
         i_memRdata  = 32'h0;
      end
   endtask

   task automatic runCycles(input int n);
      for (int k = 0; k < n; k++) applyStimulus();
   endtask

   // Assert reset, verify reset outputs, release away from the clock edge.
   task automatic doReset();
      i_arstn      = 1'b0;
      i_memRvalid  = 1'b0;
      i_memRdata   = 32'h0;
      i_redirect   = 1'b0;
      i_redirectPc = 32'h0;
      i_halt       = 1'b0;
      injectOne    = 1'b0;
      pendingQ.delete();
      expPc      = 32'h0;
      popCount   = 0;
      grantCount = 0;
      #1;
      checkOutput("rstValid", {31'h0, o_valid}, 32'h0);
      checkOutput("rstReq", {31'h0, o_memReq}, 32'h0);
      checkOutput("rstAddr", o_memAddr, 32'h0);
      checkOutput("rstPc", o_pc, 32'h0);
      checkOutput("rstInstr", o_instruction, 32'h0);
      @(posedge i_clk);
      @(posedge i_clk);
      #1;
      i_arstn = 1'b1;
   endtask

   task automatic doRedirect(input logic [31:0] pc);
      i_redirect   = 1'b1;
      i_redirectPc = pc;
      applyStimulus();
      i_redirect   = 1'b0;
      expPc        = pc & 32'hFFFF_FFFC;
   endtask

   initial begin
      compareCount = 0;
      failCount    = 0;
      i_arstn      = 1'b0;
      i_memGnt     = 1'b0;
      i_ready      = 1'b0;
      respEn       = 1'b0;
      injectOne    = 1'b0;

      // Streaming from reset: first valid after three edges, one per cycle after.
      i_memGnt = 1'b1; respEn = 1'b1; i_ready = 1'b1;
      doReset();
      applyStimulus();
      checkOutput("bootReq", {31'h0, o_memReq}, 32'h1);
      checkOutput("bootValid0", {31'h0, o_valid}, 32'h0);
      applyStimulus();
      checkOutput("bootValid1", {31'h0, o_valid}, 32'h0);
      applyStimulus();
      checkOutput("firstValid", {31'h0, o_valid}, 32'h1);
      checkOutput("firstPc", o_pc, 32'h0);
      for (int k = 0; k < 8; k++) begin
         applyStimulus();
         checkOutput("streamValid", {31'h0, o_valid}, 32'h1);
      end
      checkOutput("streamPops", 32'(popCount), 32'd8);

      // Backpressure: credit limits to exactly four grants, one pop frees one.
      i_memGnt = 1'b1; respEn = 1'b1; i_ready = 1'b0;
      doReset();
      runCycles(10);
      checkOutput("fullGrants", 32'(grantCount), 32'd4);
      checkOutput("fullReq", {31'h0, o_memReq}, 32'h0);
      checkOutput("fullValid", {31'h0, o_valid}, 32'h1);
      i_ready = 1'b1;
      applyStimulus();
      i_ready = 1'b0;
      runCycles(5);
      checkOutput("refillGrants", 32'(grantCount), 32'd5);
      checkOutput("refillReq", {31'h0, o_memReq}, 32'h0);
      checkOutput("refillHead", o_pc, 32'h4);
      checkOutput("refillAddr", o_memAddr, 32'h14);

      // Redirect with three requests outstanding: all three responses dropped.
      i_memGnt = 1'b1; respEn = 1'b0; i_ready = 1'b1;
      doReset();
      runCycles(4);
      checkOutput("preRedirGrants", 32'(grantCount), 32'd3);
      i_memGnt = 1'b0;
      doRedirect(32'h0000_0100);
      checkOutput("redirAddr", o_memAddr, 32'h100);
      checkOutput("redirEmpty", {31'h0, o_valid}, 32'h0);
      i_memGnt = 1'b1; respEn = 1'b1;
      runCycles(12);
      checkOutput("redirDelivered", 32'(popCount > 0), 32'h1);

      // Redirect coinciding with rvalid and a pop; then PC wrap-around.
      i_memGnt = 1'b1; respEn = 1'b1; i_ready = 1'b1;
      doReset();
      runCycles(6);
      checkOutput("coinValid", {31'h0, o_valid}, 32'h1);
      popBefore = popCount;
      doRedirect(32'h0000_0200);
      checkOutput("coinPop", 32'(popCount), 32'(popBefore + 1));
      checkOutput("coinFlush", {31'h0, o_valid}, 32'h0);
      runCycles(6);
      checkOutput("coinResume", 32'(popCount > popBefore + 2), 32'h1);
      doRedirect(32'hFFFF_FFF8);
      runCycles(8);
      checkOutput("wrapPc", o_pc, expPc);

`ifdef IFETCH_MISALIGN_TRAP_EN
      doRedirect(32'h0000_0302);
      checkOutput("trapSet", {31'h0, o_misalign}, 32'h1);
      runCycles(3);
      checkOutput("trapReq", {31'h0, o_memReq}, 32'h0);
      doRedirect(32'h0000_0300);
      checkOutput("trapClear", {31'h0, o_misalign}, 32'h0);
      runCycles(6);
      checkOutput("trapResume", o_pc, expPc);
`else
      doRedirect(32'h0000_0302);
      checkOutput("maskAddr", o_memAddr, 32'h300);
      runCycles(6);
      checkOutput("maskResume", o_pc, expPc);
`endif

      // Halt with two outstanding: both land, no request until halt drops.
      i_memGnt = 1'b1; respEn = 1'b0; i_ready = 1'b0;
      doReset();
      runCycles(3);
      checkOutput("haltPreGrants", 32'(grantCount), 32'd2);
      i_halt = 1'b1; i_memGnt = 1'b0;
      applyStimulus();
      i_memGnt = 1'b1; respEn = 1'b1;
      for (int k = 0; k < 6; k++) begin
         applyStimulus();
         checkOutput("haltReq", {31'h0, o_memReq}, 32'h0);
      end
      checkOutput("haltGrants", 32'(grantCount), 32'd2);
      checkOutput("haltValid", {31'h0, o_valid}, 32'h1);
      i_ready = 1'b1;
      runCycles(2);
      i_ready = 1'b0;
      checkOutput("haltPops", 32'(popCount), 32'd2);
      checkOutput("haltDrained", {31'h0, o_valid}, 32'h0);
      i_halt = 1'b0;
      applyStimulus();
      checkOutput("unhaltReq", {31'h0, o_memReq}, 32'h1);
      checkOutput("unhaltAddr", o_memAddr, 32'h8);

      // Stray rvalid with nothing in flight is ignored.
      i_memGnt = 1'b0; respEn = 1'b1; i_ready = 1'b0;
      doReset();
      applyStimulus();
      injectOne = 1'b1;
      runCycles(2);
      checkOutput("strayIgnored", {31'h0, o_valid}, 32'h0);
      i_memGnt = 1'b1; i_ready = 1'b1;
      runCycles(6);
      checkOutput("strayResume", 32'(popCount > 0), 32'h1);

      // Asynchronous reset mid-stream with the FIFO half full.
      i_memGnt = 1'b1; respEn = 1'b1; i_ready = 1'b0;
      doReset();
      runCycles(4);
      checkOutput("midValid", {31'h0, o_valid}, 32'h1);
      #2;
      i_arstn = 1'b0;
      #1;
      checkOutput("asyncValid", {31'h0, o_valid}, 32'h0);
      checkOutput("asyncReq", {31'h0, o_memReq}, 32'h0);
      checkOutput("asyncAddr", o_memAddr, 32'h0);
      i_ready = 1'b1;
      doReset();
      runCycles(3);
      checkOutput("restartValid", {31'h0, o_valid}, 32'h1);
      checkOutput("restartPc", o_pc, 32'h0);
      runCycles(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule
